// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU op codes, arbiter state encoding,
// latched request control payload and the op-legality check.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef logic [OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b010;
    localparam alu_op_t ALU_SUB = 3'b110;
    localparam alu_op_t ALU_AND = 3'b000;
    localparam alu_op_t ALU_OR  = 3'b001;
    localparam alu_op_t ALU_SLT = 3'b111;

    // Control code driven to the ALU out of reset.
    localparam alu_op_t ALU_RESET_OP = ALU_ADD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Control fields captured alongside the operands when a request is accepted.
    typedef struct packed {
        alu_op_t op;
        logic    err;
        logic    winner;
    } req_ctl_t;

    function automatic logic op_legal(input alu_op_t op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Client-side request/response bundle of the ALU arbiter.
// master = requesting clients, slave = the arbiter.
interface alu_arbiter_if #(
    parameter int unsigned W = 32
) ();

    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [2:0]   req0_op;
    logic [2:0]   req1_op;

    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_zero;
    logic         rsp_err;

    modport master (
        output req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational 2-way winner select. Round-robin on last grant by default;
// define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module rr_pick (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant,
    output logic       winner
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;

    assign winner = ~valid[0];
`else
    // On a tie the requester not served last wins; a lone requester always wins.
    assign winner = (&valid) ? ~last : valid[1];
`endif

    assign grant = (valid == 2'b00) ? 2'b00 : (winner ? 2'b10 : 2'b01);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for the shared ALU: accept, drive ALU from
// latched operands, capture result and return it on the winner's response channel.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority in rr_pick.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [2:0]    alu_control,
    input  logic [W-1:0]  alu_result,
    input  logic          alu_zero
);

    arb_state_t   state;
    arb_state_t   state_nxt;
    logic [1:0]   grant;
    logic         pick;
    logic         last;
    logic         accept;
    alu_op_t      pick_op;

    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    req_ctl_t     ctl_q;
    logic [W-1:0] result_q;
    logic         zero_q;
    logic         err_q;

    rr_pick u_pick (
        .valid  (bus.req_valid),
        .last   (last),
        .grant  (grant),
        .winner (pick)
    );

    assign accept  = (state == ST_IDLE) && (bus.req_valid != 2'b00);
    assign pick_op = pick ? bus.req1_op : bus.req0_op;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.req_valid != 2'b00) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (bus.rsp_ready[ctl_q.winner]) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs; held low while reset is asserted
    always_comb begin
        bus.req_ready = 2'b00;
        bus.rsp_valid = 2'b00;
        if (!rst) begin
            case (state)
                ST_IDLE: bus.req_ready = grant;
                ST_RESP: bus.rsp_valid[ctl_q.winner] = 1'b1;
                default: ;
            endcase
        end
    end

    // Request latch and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            ctl_q <= '{op: ALU_RESET_OP, err: 1'b0, winner: 1'b0};
            last  <= 1'b1;
        end else if (accept) begin
            a_q   <= pick ? bus.req1_a : bus.req0_a;
            b_q   <= pick ? bus.req1_b : bus.req0_b;
            ctl_q <= '{op: pick_op, err: ~op_legal(pick_op), winner: pick};
            last  <= pick;
        end
    end

    // Result capture; an illegal op reports zero result with zero flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (state == ST_EXEC) begin
            result_q <= ctl_q.err ? '0 : alu_result;
            zero_q   <= ctl_q.err ? 1'b1 : alu_zero;
            err_q    <= ctl_q.err;
        end
    end

    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign alu_control    = ctl_q.op;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;

    int n_pass;
    int n_total;

    alu_arbiter_if #(.W(32)) bus ();

    alu_arbiter #(.W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; unsupported codes produce a^b so error masking is visible
    always_comb begin
        case (alu_control)
            3'b010:  alu_result = alu_a + alu_b;
            3'b110:  alu_result = alu_a - alu_b;
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b111:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 3'b000;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #2;
        n_total++; if (bus.req_ready !== 2'b00) $display("FAIL rst_req_ready: got %b want 00", bus.req_ready); else n_pass++;
        n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL rst_rsp_valid: got %b want 00", bus.rsp_valid); else n_pass++;
        n_total++; if (bus.rsp_result !== 32'd0) $display("FAIL rst_result: got %h want 0", bus.rsp_result); else n_pass++;
        n_total++; if ({bus.rsp_zero, bus.rsp_err} !== 2'b00) $display("FAIL rst_zero_err: got %b want 00", {bus.rsp_zero, bus.rsp_err}); else n_pass++;
        n_total++; if ({alu_a, alu_b} !== 64'd0) $display("FAIL rst_alu_ab: got %h want 0", {alu_a, alu_b}); else n_pass++;
        n_total++; if (alu_control !== 3'b010) $display("FAIL rst_alu_ctl: got %b want 010", alu_control); else n_pass++;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        step();
        bus.req_valid = 2'b01; bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_op = 3'b010;
        #1;
        n_total++; if (bus.req_ready !== 2'b01) $display("FAIL single_accept: got %b want 01", bus.req_ready); else n_pass++;
        step();
        bus.req_valid = 2'b00;
        #1;
        n_total++; if ({alu_a, alu_b} !== {32'd5, 32'd7}) $display("FAIL single_alu_ab: got %h want 0000000500000007", {alu_a, alu_b}); else n_pass++;
        n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL single_exec_valid: got %b want 00", bus.rsp_valid); else n_pass++;
        step();
        #1;
        n_total++; if (bus.rsp_valid !== 2'b01) $display("FAIL single_rsp_valid: got %b want 01", bus.rsp_valid); else n_pass++;
        n_total++; if (bus.rsp_result !== 32'd12) $display("FAIL single_result: got %0d want 12", bus.rsp_result); else n_pass++;
        n_total++; if ({bus.rsp_zero, bus.rsp_err} !== 2'b00) $display("FAIL single_zero_err: got %b want 00", {bus.rsp_zero, bus.rsp_err}); else n_pass++;
        bus.rsp_ready = 2'b01;
        step();
        bus.rsp_ready = 2'b00;
        #1;
        n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL single_done: got %b want 00", bus.rsp_valid); else n_pass++;
        n_total++; if (alu_a !== 32'd5) $display("FAIL single_alu_hold: got %0d want 5", alu_a); else n_pass++;
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g;
        logic [2:0] exp_op;
        do_reset();
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
`endif
            exp_op = (exp_g == 2'b01) ? 3'b110 : 3'b001;
            step();
            bus.req_valid = 2'b11; bus.rsp_ready = 2'b11;
            bus.req0_a = 32'd9; bus.req0_b = 32'd9; bus.req0_op = 3'b110;
            bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_op = 3'b001;
            #1;
            n_total++; if (bus.req_ready !== exp_g) $display("FAIL alt_grant%0d: got %b want %b", k, bus.req_ready, exp_g); else n_pass++;
            step();
            #1;
            n_total++; if (alu_control !== exp_op) $display("FAIL alt_op%0d: got %b want %b", k, alu_control, exp_op); else n_pass++;
            step();
            #1;
            n_total++; if (bus.rsp_valid !== exp_g) $display("FAIL alt_rsp%0d: got %b want %b", k, bus.rsp_valid, exp_g); else n_pass++;
            n_total++; if ({bus.rsp_result, bus.rsp_zero} !== {32'd0, 1'b1}) $display("FAIL alt_res%0d: got %h/%b want 0/1", k, bus.rsp_result, bus.rsp_zero); else n_pass++;
        end
        step();
        clear_inputs();
    endtask

    task automatic test_illegal_op();
        step();
        bus.req_valid = 2'b10; bus.req1_a = 32'd3; bus.req1_b = 32'd4; bus.req1_op = 3'b011;
        #1;
        n_total++; if (bus.req_ready !== 2'b10) $display("FAIL ill_accept: got %b want 10", bus.req_ready); else n_pass++;
        step();
        bus.req_valid = 2'b00;
        #1;
        n_total++; if (alu_control !== 3'b011) $display("FAIL ill_alu_ctl: got %b want 011", alu_control); else n_pass++;
        step();
        #1;
        n_total++; if (bus.rsp_valid !== 2'b10) $display("FAIL ill_rsp_valid: got %b want 10", bus.rsp_valid); else n_pass++;
        n_total++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {32'd0, 2'b11}) $display("FAIL ill_result: got %h/%b/%b want 0/1/1", bus.rsp_result, bus.rsp_zero, bus.rsp_err); else n_pass++;
        bus.rsp_ready = 2'b10;
        step();
        bus.rsp_ready = 2'b00;
        #1;
        n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL ill_done: got %b want 00", bus.rsp_valid); else n_pass++;
        // Legal follow-up must clear the error flag
        step();
        bus.req_valid = 2'b10; bus.req1_op = 3'b010;
        #1;
        n_total++; if (bus.req_ready !== 2'b10) $display("FAIL ill_next_accept: got %b want 10", bus.req_ready); else n_pass++;
        step();
        bus.req_valid = 2'b00;
        step();
        #1;
        n_total++; if ({bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {2'b10, 32'd7, 2'b00}) $display("FAIL ill_next_rsp: got %b/%h/%b/%b want 10/7/0/0", bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_err); else n_pass++;
        bus.rsp_ready = 2'b10;
        step();
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_back_pressure();
        step();
        bus.req_valid = 2'b01; bus.req0_a = 32'hF0; bus.req0_b = 32'h3C; bus.req0_op = 3'b000;
        #1;
        n_total++; if (bus.req_ready !== 2'b01) $display("FAIL bp_accept: got %b want 01", bus.req_ready); else n_pass++;
        step();
        bus.req_valid = 2'b10; bus.req1_a = 32'd1; bus.req1_b = 32'd2; bus.req1_op = 3'b111;
        #1;
        n_total++; if (bus.req_ready !== 2'b00) $display("FAIL bp_exec_ready: got %b want 00", bus.req_ready); else n_pass++;
        step();
        bus.rsp_ready = 2'b10;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_total++; if ({bus.rsp_valid, bus.req_ready, bus.rsp_result} !== {2'b01, 2'b00, 32'h30}) $display("FAIL bp_hold%0d: got %b/%b/%h want 01/00/30", k, bus.rsp_valid, bus.req_ready, bus.rsp_result); else n_pass++;
            step();
            #1;
        end
        bus.rsp_ready = 2'b01;
        #1;
        n_total++; if (bus.rsp_valid !== 2'b01) $display("FAIL bp_handshake: got %b want 01", bus.rsp_valid); else n_pass++;
        step();
        bus.rsp_ready = 2'b00;
        #1;
        n_total++; if (bus.req_ready !== 2'b10) $display("FAIL bp_next_grant: got %b want 10", bus.req_ready); else n_pass++;
        step();
        bus.req_valid = 2'b00;
        step();
        #1;
        n_total++; if ({bus.rsp_valid, bus.rsp_result} !== {2'b10, 32'd1}) $display("FAIL bp_req1_rsp: got %b/%h want 10/1", bus.rsp_valid, bus.rsp_result); else n_pass++;
        bus.rsp_ready = 2'b10;
        step();
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_reset_in_exec();
        step();
        bus.req_valid = 2'b01; bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req0_op = 3'b010;
        step();
        bus.req_valid = 2'b00;
        rst = 1'b1;
        #1;
        n_total++; if ({bus.req_ready, bus.rsp_valid} !== 4'b0000) $display("FAIL rx_handshake: got %b want 0000", {bus.req_ready, bus.rsp_valid}); else n_pass++;
        n_total++; if ({alu_a, alu_b, alu_control} !== {64'd0, 3'b010}) $display("FAIL rx_alu: got %h/%b want 0/010", {alu_a, alu_b}, alu_control); else n_pass++;
        n_total++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {32'd0, 2'b00}) $display("FAIL rx_rsp: got %h/%b/%b want 0/0/0", bus.rsp_result, bus.rsp_zero, bus.rsp_err); else n_pass++;
        step();
        rst = 1'b0;
        step();
        step();
        #1;
        n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL rx_dropped: got %b want 00", bus.rsp_valid); else n_pass++;
        step();
        bus.req_valid = 2'b10; bus.req1_a = 32'd10; bus.req1_b = 32'd3; bus.req1_op = 3'b110;
        #1;
        n_total++; if (bus.req_ready !== 2'b10) $display("FAIL rx_next_accept: got %b want 10", bus.req_ready); else n_pass++;
        step();
        bus.req_valid = 2'b00;
        #1;
        n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL rx_next_exec: got %b want 00", bus.rsp_valid); else n_pass++;
        step();
        #1;
        n_total++; if ({bus.rsp_valid, bus.rsp_result} !== {2'b10, 32'd7}) $display("FAIL rx_next_rsp: got %b/%h want 10/7", bus.rsp_valid, bus.rsp_result); else n_pass++;
        bus.rsp_ready = 2'b10;
        step();
        bus.rsp_ready = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single();
        test_alternate();
        test_illegal_op();
        test_back_pressure();
        test_reset_in_exec();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU. Accepts operation requests from two independent clients over valid/ready handshakes, grants one at a time (round-robin), drives the ALU from registered operands, captures result and zero flag, and returns them on the granted client's response channel. Sits between the ALU and its clients, such as the main datapath and an address/compare unit.

## Interface
- `W`, default 32: operand/result width; must match the ALU.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid[1:0]` in 2: request valid, one bit per requester.
- `req_ready[1:0]` out 2: request accepted this cycle; at most one bit high.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in W: operands.
- `req0_op`, `req1_op` in 3: ALU control code.
- `rsp_valid[1:0]` out 2: response valid; at most one bit high.
- `rsp_ready[1:0]` in 2: requester consumes the response.
- `rsp_result` out W: registered result, shared by both response channels.
- `rsp_zero` out 1: registered zero flag.
- `rsp_err` out 1: the op code was unsupported.
- `alu_a`, `alu_b` out W: to the ALU operands.
- `alu_control` out 3: to the ALU control input.
- `alu_result` in W: from the ALU.
- `alu_zero` in 1: from the ALU.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is high, pick a winner, assert `req_ready[winner]` combinationally, latch a/b/op/winner, and go to EXEC.
  - Otherwise stay in IDLE.
- Round-robin rule:
  - Pointer `last` holds the most recently granted requester.
  - When both requesters are valid, grant `~last`; a single valid requester always wins.
  - `last` updates on grant.
- EXEC:
  - `alu_a`, `alu_b` and `alu_control` carry the latched values.
  - At the clock edge, capture `alu_result` into `rsp_result` and `alu_zero` into `rsp_zero`.
  - Go to RESP.
- Op legality:
  - Legal codes are 010 add, 110 sub, 000 and, 001 or, 111 slt.
  - Any other code is checked at latch time. It still passes through EXEC, but captures `rsp_result`=0, `rsp_zero`=1, `rsp_err`=1.
  - `rsp_err`=0 for legal codes.
- RESP:
  - `rsp_valid[winner]` is high; result, zero and err are held stable.
  - When `rsp_ready[winner]` is high, go to IDLE.
  - `rsp_ready` of the non-granted requester is ignored.
- Outside EXEC, `alu_*` outputs hold their last latched values. They are not X.
- Requests are not accepted in EXEC or RESP; `req_ready`=0.

## Timing
- Reset values:
  - State IDLE, `last`=1 (so requester 0 wins the first tie).
  - `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_err`=0.
  - `alu_a`=0, `alu_b`=0, `alu_control`=3'b010.
- Latency: accept in cycle N, EXEC in N+1, `rsp_valid` high in N+2.
- Throughput: at best one operation per 3 cycles (the accept cycle in IDLE, then EXEC, then the RESP handshake).
- Response handshake completes in the cycle where `rsp_valid` and `rsp_ready` are both high. The next accept can happen in the following cycle.
- Reset asserted mid-operation forces IDLE immediately. An in-flight operation is dropped with no response.
- Requester inputs must stay stable only in the accept cycle.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: fixed priority, requester 0 always wins a tie; `last` is unused.
- Undefined (default): round-robin as described in Operation.

## Structure
- Shared package `alu_pkg`:
  - ALU op constants `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`.
  - Arbiter state encoding.
  - Op-legality function.
- One sub-module, `rr_pick`: a combinational 2-way winner select taking `valid[1:0]` and `last`, producing grant one-hot and winner index. It contains the `ALU_ARB_FIXED_PRIO_EN` switch.
- The ALU itself is instantiated outside the arbiter by the parent.

## Test plan
- Reset, then req0 add a=5 b=7 alone: `req_ready`=01 in the accept cycle, `rsp_valid`=01 two cycles later, `rsp_result`=12, `rsp_zero`=0, `rsp_err`=0.
- Both valid every cycle, req0 sub 9-9, req1 or 0|0: grants alternate 0,1,0,1. Each response has `rsp_result`=0 and `rsp_zero`=1. With `ALU_ARB_FIXED_PRIO_EN`, all grants go to 0.
- req1 op=3'b011 with a=3 b=4: `rsp_err`=1, `rsp_result`=0, `rsp_zero`=1, FSM returns to IDLE normally.
- Back-pressure: `rsp_ready[0]` held low 5 cycles after `rsp_valid[0]`. Result stays stable, `req_ready`=00 throughout, and the pending req1 is granted the cycle after the handshake.
- `rst` pulsed during EXEC: all outputs at reset values the same cycle and no `rsp_valid`. The next request completes with correct latency.
